// File: rtl/parity_pkg.sv
// Shared definitions for the parity framer: state encoding, parity modes, index sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package parity_pkg;

    // Framer FSM state encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    // Parity mode as carried on odd_sel
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Width of a bit index that can address every bit of a DATA_W word
    function automatic int idx_width(input int data_w);
        return (data_w < 2) ? 1 : $clog2(data_w);
    endfunction

endpackage

// File: rtl/parity_reduce.sv
// Parity bit generator: XOR of all word bits, inverted when odd parity is selected.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, only sampled by the framer at accept.
module parity_reduce #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic              odd_sel,
    output logic              p
);

    // Even parity makes the total count of ones even; odd_sel flips that sense
    assign p = (^data) ^ odd_sel;

endmodule

// File: rtl/parity_serial_framer.sv
// Word-to-serial framer: shifts a word out LSB-first followed by one parity bit.
// Latency: first data bit on ser_out one cycle after accept; DATA_W+1 cycles per frame.
// Backpressure: ser_ready=0 freezes all state; in_ready follows ser_ready in the parity cycle.
module parity_serial_framer
    import parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              odd_sel,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int IDX_W = idx_width(DATA_W);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [DATA_W-1:0] shift_q;
    logic              par_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              par_new;
    logic              accept;
    logic              last_data;

    parity_reduce #(
        .DATA_W (DATA_W)
    ) u_parity_reduce (
        .data    (in_data),
        .odd_sel (odd_sel),
        .p       (par_new)
    );

    // A new word is taken whenever the producer offers one while we can take it
    assign accept    = in_valid && in_ready;
    assign last_data = (idx_q == IDX_W'(DATA_W - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: advance only on sink handshakes; parity handshake may chain a new frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = DATA;
            end
            DATA: begin
                if (ser_ready && last_data) state_d = PARITY;
            end
            PARITY: begin
                if (ser_ready) state_d = in_valid ? DATA : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: serial bit is forced low whenever it is not valid
    always_comb begin
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        ser_last  = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            DATA: begin
                ser_valid = 1'b1;
                ser_out   = shift_q[0];
                busy      = 1'b1;
            end
            PARITY: begin
                in_ready  = ser_ready;
                ser_valid = 1'b1;
                ser_out   = par_q;
                ser_last  = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Datapath: load on accept, shift on each accepted data bit, count finished frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            par_q   <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (state_q == DATA && ser_ready) begin
                shift_q <= shift_q >> 1;
                idx_q   <= idx_q + IDX_W'(1);
            end
            if (state_q == PARITY && ser_ready) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // Accept wins over the shift/index update; it can only coincide with PARITY
            if (accept) begin
                shift_q <= in_data;
                par_q   <= par_new;
                idx_q   <= '0;
            end
        end
    end

    assign frame_cnt = cnt_q;

endmodule
